// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: turns the M-stage access into a req/ready
// bus transaction, stalls the pipeline until it completes, and formats lanes.
//
// state | meaning
// IDLE  | no transaction; a clean access raises stallm and launches next edge
// BUSY  | dmem_req high, waiting for dmem_ready or timeout
// DONE  | one-cycle release so the instruction advances to WB
module mem_stage_lsu #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwritem,
    input  logic [1:0]  resultsrcm,
    input  logic [2:0]  funct3m,
    input  logic [31:0] aluresultm,
    input  logic [31:0] writedatam,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    output logic [31:0] readdatam,
    output logic        stallm,
    output logic        misalignm,
    output logic        buserrm
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]      state;
    logic [TO_W-1:0] cnt;
    logic            we_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      be_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;

    logic            access, f3_ok, aligned, fault, start, busy, timeout;
    logic [3:0]      be_n;
    logic [31:0]     wdata_n;

    always_comb begin
        access = memwritem | (resultsrcm == 2'b01);
        f3_ok  = 1'b0;
        case (funct3m)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = ~memwritem;
            default:                f3_ok = 1'b0;
        endcase
        aligned = 1'b1;
        case (funct3m[1:0])
            2'b01:   aligned = ~aluresultm[0];
            2'b10:   aligned = (aluresultm[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        fault   = access & (~f3_ok | ~aligned);
        start   = (state == IDLE) & access & ~fault;
        busy    = (state == BUSY);
        timeout = busy & ~dmem_ready & (cnt == TO_W'(TIMEOUT - 1));
    end

    // Loads always read the whole word; lanes are picked on return.
    always_comb begin
        be_n    = 4'b1111;
        wdata_n = 32'h0;
        if (memwritem) begin
            case (funct3m[1:0])
                2'b00: begin
                    be_n    = 4'b0001 << aluresultm[1:0];
                    wdata_n = {4{writedatam[7:0]}};
                end
                2'b01: begin
                    be_n    = aluresultm[1] ? 4'b1100 : 4'b0011;
                    wdata_n = {2{writedatam[15:0]}};
                end
                default: begin
                    be_n    = 4'b1111;
                    wdata_n = writedatam;
                end
            endcase
        end
    end

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*off +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b100:  load_ext = {24'h0, b};
            3'b101:  load_ext = {16'h0, h};
            default: load_ext = w;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            be_q      <= 4'h0;
            f3_q      <= 3'h0;
            off_q     <= 2'h0;
            readdatam <= 32'h0;
            buserrm   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    buserrm <= 1'b0;
                    cnt     <= '0;
                    if (start) begin
                        we_q    <= memwritem;
                        addr_q  <= {aluresultm[31:2], 2'b00};
                        wdata_q <= wdata_n;
                        be_q    <= be_n;
                        f3_q    <= funct3m;
                        off_q   <= aluresultm[1:0];
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (dmem_ready) begin
                        if (!we_q) readdatam <= load_ext(f3_q, off_q, dmem_rdata);
                        cnt   <= '0;
                        state <= DONE;
                    end else if (timeout) begin
                        readdatam <= 32'h0;
                        buserrm   <= 1'b1;
                        cnt       <= '0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + TO_W'(1);
                    end
                end
                default: begin
                    buserrm <= 1'b0;
                    cnt     <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign dmem_req   = busy;
    assign dmem_we    = busy & we_q;
    assign dmem_addr  = busy ? addr_q  : 32'h0;
    assign dmem_wdata = busy ? wdata_q : 32'h0;
    assign dmem_be    = busy ? be_q    : 4'h0;
    assign stallm     = reset & (start | busy);
    assign misalignm  = reset & (state == IDLE) & fault;

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Memory-stage load/store unit of the 5-stage RISC-V pipeline. It sits between the EX/MEM register and the MEM/WB register. It turns the M-stage load/store into a req/ready transaction on the data-memory bus and stalls the pipeline until that transaction completes. It also formats store byte-lanes and sign/zero-extends load data into readdatam for writeback.

Parameters:
TIMEOUT, 255, max BUSY cycles without dmem_ready before abort (1..2^TO_W-1)
TO_W, 8, width of timeout counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
memwritem  input  1  M-stage store
resultsrcm  input  2  M-stage result select; 2'b01 = load
funct3m  input  3  RV32I load/store funct3
aluresultm  input  32  effective byte address
writedatam  input  32  store data (rs2)
dmem_ready  input  1  memory completes current request
dmem_rdata  input  32  read word, valid with dmem_ready
dmem_req  output  1  request active
dmem_we  output  1  1 = write
dmem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
dmem_wdata  output  32  lane-replicated store data
dmem_be  output  4  byte enables
readdatam  output  32  extended load data, to MEM/WB
stallm  output  1  hold IF..M stages
misalignm  output  1  access fault (misaligned or illegal funct3)
buserrm  output  1  timeout abort

Behaviour:
- access = memwritem | (resultsrcm==2'b01). Valid funct3: loads 000/001/010/100/101; stores 000/001/010.
- fault (combinational, IDLE only): access and (illegal funct3, or half with addr[0]=1, or word with addr[1:0]!=0). misalignm=1, stallm=0, no request, readdatam unchanged.
- FSM states IDLE, BUSY, DONE.
- IDLE:
  - access and no fault: stallm=1 combinationally.
  - At the next edge, register we/addr/be/wdata, funct3 and addr[1:0], then go BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - dmem_req=1, stallm=1, bus outputs held stable.
  - Each cycle with dmem_ready=0, the counter increments.
  - dmem_ready=1: capture extended dmem_rdata into readdatam (stores leave readdatam unchanged), then go DONE.
  - dmem_ready=0 with counter==TIMEOUT-1: set buserrm and readdatam=0, then go DONE.
  - If ready and timeout fall on the same cycle, ready wins.
- DONE:
  - stallm=0 for exactly one cycle, so the instruction advances to WB on this edge.
  - buserrm remains high through DONE only.
  - Always go IDLE next.
  - Counter clears on leaving BUSY.
- Minimum access: 3 cycles (IDLE, BUSY with ready, DONE).
- dmem_ready is ignored outside BUSY. dmem_req=0 in IDLE and DONE.
- Store lanes:
  - sb: be = 4'b0001<<addr[1:0], wdata = {4{byte}}.
  - sh: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{half}}.
  - sw: be = 4'b1111.
- Loads: select byte/half from captured offset. lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through. dmem_be=4'b1111, dmem_wdata=0 for loads.
- Reset asserted (any time, including mid-BUSY):
  - State returns to IDLE; counter clears.
  - dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, readdatam and buserrm all go to 0.
  - stallm and misalignm are forced 0 while reset=0.
  - An in-flight request is abandoned; memory must tolerate req dropping.
- Non-access cycles: all outputs except readdatam low; readdatam holds its last value.

Test Plan:
- lw at 0x0000_1004, dmem_ready high in first BUSY cycle, rdata 0xDEADBEEF -> dmem_addr 0x1004, be 1111, stallm high 2 cycles; readdatam=0xDEADBEEF in DONE.
- lb at 0x2003, rdata 0x80123456 -> readdatam 0xFFFFFF80. lbu at the same address -> 0x00000080. lhu at 0x2002 -> 0x00008012.
- sh at 0x3002, writedatam 0x0000ABCD -> dmem_we=1, be 1100, wdata 0xABCDABCD, addr 0x3000; readdatam unchanged.
- lw at 0x1002 -> misalignm=1 same cycle, dmem_req never asserts, stallm=0. sw with funct3 011 -> misalignm=1.
- lw with dmem_ready delayed 5 BUSY cycles -> stallm high 6 cycles total, then DONE; buserrm stays 0. With TIMEOUT=4 and no ready -> buserrm=1 in DONE, readdatam=0, dmem_req low after 4 BUSY cycles.
- reset driven to 0 in the 2nd BUSY cycle -> dmem_req=0 and stallm=0 immediately (asynchronous). After release, an access starts a fresh IDLE→BUSY sequence.
